instr_encoder: RTL and testbench

- Sequential RV32I instruction encoder: the encode-side counterpart of the main opcode decoder.
- Accepts field-level instruction requests over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes the words to consecutive instruction-memory word addresses through a stallable write port.
- Used by the boot/program loader and test infrastructure; expands the LI pseudo-op into LUI/ADDI.

---
 rtl/instr_encoder.sv | 169 ++++++++++++++++
 tb/tb_instr_encoder.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Sequential RV32I instruction encoder: packs field-level requests into 32-bit
// words and streams them to consecutive instruction-memory addresses.
module instr_encoder #(
    parameter int ADDR_WIDTH = 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            req_kind,
    input  logic [4:0]            req_rd,
    input  logic [4:0]            req_rs1,
    input  logic [4:0]            req_rs2,
    input  logic [2:0]            req_funct3,
    input  logic [6:0]            req_funct7,
    input  logic [31:0]           req_imm,
    output logic                  wr_en,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [31:0]           wr_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_WRITE2} state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [ADDR_WIDTH-1:0] BASE      = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH:0]   COUNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]           wr_data_q, wr_data_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  err_q, err_d;
    logic [31:0]           lo_data_q, lo_data_d;
    logic                  lo_pend_q, lo_pend_d;

    logic [31:0] enc_word, enc_lo;
    logic        enc_lo_pend, enc_legal;
    logic        li_small;
    logic [19:0] li_hi;

    // (imm + 0x800)[31:12]: the carry out of the low 12 bits is exactly imm[11].
    assign li_hi    = req_imm[31:12] + {19'd0, req_imm[11]};
    assign li_small = (&req_imm[31:11]) | ~(|req_imm[31:11]);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        enc_word    = '0;
        enc_lo      = '0;
        enc_lo_pend = 1'b0;
        enc_legal   = 1'b1;
        case (req_kind)
            4'd0: enc_word = {req_funct7, req_rs2, req_rs1, req_funct3, req_rd, OP_R};
            4'd1: begin
                enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_IMM};
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101)
                    enc_word[31:20] = {req_funct7, req_imm[4:0]};
            end
            4'd2: enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OP_LOAD};
            4'd3: enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                              req_imm[4:0], OP_STORE};
            4'd4: enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                              req_imm[4:1], req_imm[11], OP_BRANCH};
            4'd5: enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                              req_rd, OP_JAL};
            4'd6: enc_word = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
            4'd7: enc_word = {req_imm[31:12], req_rd, OP_LUI};
            4'd8: enc_word = {req_imm[31:12], req_rd, OP_AUIPC};
            4'd9: begin
                if (li_small) begin
                    enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_IMM};
                end else begin
                    enc_word    = {li_hi, req_rd, OP_LUI};
                    enc_lo      = {req_imm[11:0], req_rd, 3'b000, req_rd, OP_IMM};
                    enc_lo_pend = |req_imm[11:0];
                end
            end
            default: enc_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        count_d   = count_q;
        err_d     = err_q;
        lo_data_d = lo_data_q;
        lo_pend_d = lo_pend_q;
        if (clear) begin
            state_d   = S_IDLE;
            wr_addr_d = BASE;
            count_d   = '0;
            err_d     = 1'b0;
            lo_pend_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        if (!enc_legal) begin
                            err_d = 1'b1;
                        end else begin
                            state_d   = S_WRITE;
                            wr_data_d = enc_word;
                            lo_data_d = enc_lo;
                            lo_pend_d = enc_lo_pend;
                        end
                    end
                end
                S_WRITE, S_WRITE2: begin
                    if (wr_ready) begin
                        wr_addr_d = wr_addr_q + 1'b1;
                        if (count_q != COUNT_MAX) count_d = count_q + 1'b1;
                        if (state_q == S_WRITE && lo_pend_q) begin
                            state_d   = S_WRITE2;
                            wr_data_d = lo_data_q;
                            lo_pend_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            wr_addr_q <= BASE;
            wr_data_q <= '0;
            count_q   <= '0;
            err_q     <= 1'b0;
            lo_data_q <= '0;
            lo_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            count_q   <= count_d;
            err_q     <= err_d;
            lo_data_q <= lo_data_d;
            lo_pend_q <= lo_pend_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && !clear;
    assign wr_en     = (state_q != S_IDLE);
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed, table-driven bench for instr_encoder, plus hand sequences for
// stalls, illegal kinds, clear, reset abort and address wrap/count saturation.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n, clear, req_valid, req_valid2, wr_ready;
    logic [3:0]  req_kind;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [6:0]  req_funct7;
    logic [31:0] req_imm;

    logic        req_ready, wr_en, err;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic [8:0]  count;

    logic        u2_ready, u2_wr_en, u2_err;
    logic [1:0]  u2_addr;
    logic [31:0] u2_data;
    logic [2:0]  u2_count;

    int n_vec = 0;
    int n_bad = 0;
    int exp_addr = 0;
    int exp_count = 0;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid),
        .req_ready(req_ready), .req_kind(req_kind), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
        .req_funct7(req_funct7), .req_imm(req_imm), .wr_en(wr_en),
        .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .count(count), .err(err)
    );

    instr_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .req_valid(req_valid2),
        .req_ready(u2_ready), .req_kind(req_kind), .req_rd(req_rd),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_funct3(req_funct3),
        .req_funct7(req_funct7), .req_imm(req_imm), .wr_en(u2_wr_en),
        .wr_ready(wr_ready), .wr_addr(u2_addr), .wr_data(u2_data),
        .count(u2_count), .err(u2_err)
    );

    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        two;
        logic [31:0] w0, w1;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(logic [3:0] kind, logic [4:0] rd, logic [4:0] rs1,
                                logic [4:0] rs2, logic [2:0] f3, logic [6:0] f7,
                                logic [31:0] imm, logic two, logic [31:0] w0,
                                logic [31:0] w1);
        vec_t v;
        v.kind = kind; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.two = two; v.w0 = w0; v.w1 = w1;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits (bounded) for ready on the selected instance, then presents one request cycle.
    task automatic issue(input bit sel, input vec_t v);
        int t;
        @(negedge clk);
        t = 0;
        while (!(sel ? u2_ready : req_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("req_ready_wait", {31'd0, sel ? u2_ready : req_ready}, 32'd1);
        req_kind = v.kind; req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2;
        req_funct3 = v.f3; req_funct7 = v.f7; req_imm = v.imm;
        if (sel) req_valid2 = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_valid2 = 1'b0;
    endtask

    function automatic int sat4(int c);
        return (c > 4) ? 4 : c;
    endfunction

    initial begin
        vec_t v;
        rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_valid2 = 1'b0; wr_ready = 1'b1;
        req_kind = '0; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
        req_funct3 = '0; req_funct7 = '0; req_imm = '0;

        vecs[0]  = mk(4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd5,        1'b0, 32'h00500093, 32'h0);
        vecs[1]  = mk(4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFFFFFC, 1'b0, 32'hFE208EE3, 32'h0);
        vecs[2]  = mk(4'd5, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd8,        1'b0, 32'h008000EF, 32'h0);
        vecs[3]  = mk(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345FFF, 1'b1, 32'h123462B7, 32'hFFF28293);
        vecs[4]  = mk(4'd9, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 1'b0, 32'h000012B7, 32'h0);
        vecs[5]  = mk(4'd9, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 1'b0, 32'hFFF00093, 32'h0);
        vecs[6]  = mk(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h0,        1'b0, 32'h402081B3, 32'h0);
        vecs[7]  = mk(4'd1, 5'd3, 5'd1, 5'd0, 3'd5, 7'h20, 32'd4,        1'b0, 32'h4040D193, 32'h0);
        vecs[8]  = mk(4'd2, 5'd4, 5'd2, 5'd0, 3'd2, 7'h7F, 32'hFFFFFFF8, 1'b0, 32'hFF812203, 32'h0);
        vecs[9]  = mk(4'd3, 5'd0, 5'd2, 5'd5, 3'd2, 7'h00, 32'd12,       1'b0, 32'h00512623, 32'h0);
        vecs[10] = mk(4'd6, 5'd1, 5'd6, 5'd0, 3'd7, 7'h00, 32'h10,       1'b0, 32'h010300E7, 32'h0);
        vecs[11] = mk(4'd7, 5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'hABCDE000, 1'b0, 32'hABCDE3B7, 32'h0);
        vecs[12] = mk(4'd8, 5'd8, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00001000, 1'b0, 32'h00001417, 32'h0);
        vecs[13] = mk(4'd9, 5'd6, 5'd0, 5'd0, 3'd0, 7'h00, 32'h000007FF, 1'b0, 32'h7FF00313, 32'h0);
        vecs[14] = mk(4'd9, 5'd6, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000800, 1'b1, 32'h00001337, 32'h80030313);

        #12;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_wr_en",     {31'd0, wr_en},     32'd0);
        check("rst_wr_addr",   {24'd0, wr_addr},   32'd0);
        check("rst_wr_data",   wr_data,            32'd0);
        check("rst_count",     {23'd0, count},     32'd0);
        check("rst_err",       {31'd0, err},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            issue(1'b0, vecs[i]);
            check($sformatf("v%0d_wr_en", i),   {31'd0, wr_en},   32'd1);
            check($sformatf("v%0d_w0", i),      wr_data,          vecs[i].w0);
            check($sformatf("v%0d_addr0", i),   {24'd0, wr_addr}, exp_addr);
            check($sformatf("v%0d_busy", i),    {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
            exp_addr++; exp_count++;
            if (vecs[i].two) begin
                check($sformatf("v%0d_wr_en2", i), {31'd0, wr_en},   32'd1);
                check($sformatf("v%0d_w1", i),     wr_data,          vecs[i].w1);
                check($sformatf("v%0d_addr1", i),  {24'd0, wr_addr}, exp_addr);
                @(posedge clk); #1;
                exp_addr++; exp_count++;
            end
            check($sformatf("v%0d_idle", i),  {31'd0, wr_en},     32'd0);
            check($sformatf("v%0d_ready", i), {31'd0, req_ready}, 32'd1);
            check($sformatf("v%0d_count", i), {23'd0, count},     exp_count);
        end

        // Memory stall: three cycles of wr_ready low hold the write.
        wr_ready = 1'b0;
        v = mk(4'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'h00, 32'd1, 1'b0, 32'h00100113, 32'h0);
        issue(1'b0, v);
        for (int k = 0; k < 3; k++) begin
            check("stall_wr_en", {31'd0, wr_en},     32'd1);
            check("stall_addr",  {24'd0, wr_addr},   exp_addr);
            check("stall_data",  wr_data,            32'h00100113);
            check("stall_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        wr_ready = 1'b1;
        @(posedge clk); #1;
        exp_addr++; exp_count++;
        check("stall_done_wr_en", {31'd0, wr_en},   32'd0);
        check("stall_done_addr",  {24'd0, wr_addr}, exp_addr);
        check("stall_done_count", {23'd0, count},   exp_count);
        @(posedge clk); #1;
        check("stall_once_addr",  {24'd0, wr_addr}, exp_addr);

        // Illegal kind is consumed without a write.
        v = mk(4'd15, 5'd1, 5'd1, 5'd1, 3'd0, 7'h00, 32'h0, 1'b0, 32'h0, 32'h0);
        issue(1'b0, v);
        check("ill_wr_en", {31'd0, wr_en},     32'd0);
        check("ill_err",   {31'd0, err},       32'd1);
        check("ill_addr",  {24'd0, wr_addr},   exp_addr);
        check("ill_ready", {31'd0, req_ready}, 32'd1);

        // Clear after the LUI half of a two-word LI drops the ADDI half.
        issue(1'b0, vecs[3]);
        @(posedge clk); #1;
        check("clr_pre_data", wr_data, 32'hFFF28293);
        @(negedge clk);
        clear = 1'b1;
        #1;
        check("clr_ready_low", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        check("clr_wr_en", {31'd0, wr_en},   32'd0);
        check("clr_addr",  {24'd0, wr_addr}, 32'd0);
        check("clr_count", {23'd0, count},   32'd0);
        check("clr_err",   {31'd0, err},     32'd0);
        @(negedge clk);
        clear = 1'b0;
        exp_addr = 0; exp_count = 0;

        // Asynchronous reset aborts a stalled write immediately.
        wr_ready = 1'b0;
        issue(1'b0, vecs[0]);
        check("rstw_wr_en_pre", {31'd0, wr_en}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rstw_wr_en", {31'd0, wr_en},   32'd0);
        check("rstw_addr",  {24'd0, wr_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_ready = 1'b1;

        // Narrow instance: address wrap and count saturation.
        for (int i = 0; i < 5; i++) begin
            issue(1'b1, vecs[0]);
            check($sformatf("w%0d_wr_en", i), {31'd0, u2_wr_en}, 32'd1);
            check($sformatf("w%0d_addr", i),  {30'd0, u2_addr},  i % 4);
            @(posedge clk); #1;
            check($sformatf("w%0d_count", i), {29'd0, u2_count}, sat4(i + 1));
        end
        check("w_final_addr", {30'd0, u2_addr}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
